// File: rtl/ttt_game_ctrl_if.sv
// Move handshake between the move-entry logic and the tic-tac-toe game controller.
interface ttt_game_ctrl_if;
   logic       move_valid;
   logic [3:0] move_pos;
   logic       move_ready;

   modport master (output move_valid, output move_pos, input move_ready);
   modport slave  (input move_valid, input move_pos, output move_ready);
endinterface

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: board storage, move handshake, and a sequential
// line scan through one shared three-in-a-row evaluator.
//
//   state | meaning
//   WAIT  | ready for a move; illegal moves are consumed and flagged
//   SCAN  | evaluating lines 0..7, one per cycle, after a legal move
//   DONE  | game ended (win or draw); holds until new_game or reset

module detect_3inarow (
   input  logic [1:0] cell_a,
   input  logic [1:0] cell_b,
   input  logic [1:0] cell_c,
   output logic       winner,
   output logic [1:0] who
);
   assign winner = (cell_a != 2'b00) && (cell_a == cell_b) && (cell_b == cell_c);
   assign who    = winner ? cell_a : 2'b00;
endmodule

module ttt_game_ctrl #(
   parameter logic [1:0] FIRST_PLAYER = 2'b01
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               new_game,
   ttt_game_ctrl_if.slave     mv,
   output logic [17:0]        board,
   output logic [1:0]         turn,
   output logic               illegal_move,
   output logic               game_over,
   output logic [1:0]         who_win,
   output logic [2:0]         win_line,
   output logic               draw
);

   typedef enum logic [1:0] {
      WAIT = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [17:0] board_q, board_d;
   logic [1:0]  turn_q, turn_d;
   logic [3:0]  move_cnt_q, move_cnt_d;
   logic [2:0]  line_cnt_q, line_cnt_d;
   logic        hit_q, hit_d;
   logic [2:0]  hit_line_q, hit_line_d;
   logic [1:0]  hit_who_q, hit_who_d;
   logic        illegal_q, illegal_d;
   logic        game_over_q, game_over_d;
   logic [1:0]  who_win_q, who_win_d;
   logic [2:0]  win_line_q, win_line_d;
   logic        draw_q, draw_d;

   logic [1:0]  cells [9];
   logic [3:0]  idx_a, idx_b, idx_c;
   logic        det_winner;
   logic [1:0]  det_who;
   logic [1:0]  pos_cell;
   logic        move_legal;

   always_comb begin
      for (int i = 0; i < 9; i++) cells[i] = board_q[2*i +: 2];
   end

   always_comb begin
      idx_a = 4'd0;
      idx_b = 4'd1;
      idx_c = 4'd2;
      case (line_cnt_q)
         3'd0: begin idx_a = 4'd0; idx_b = 4'd1; idx_c = 4'd2; end
         3'd1: begin idx_a = 4'd3; idx_b = 4'd4; idx_c = 4'd5; end
         3'd2: begin idx_a = 4'd6; idx_b = 4'd7; idx_c = 4'd8; end
         3'd3: begin idx_a = 4'd0; idx_b = 4'd3; idx_c = 4'd6; end
         3'd4: begin idx_a = 4'd1; idx_b = 4'd4; idx_c = 4'd7; end
         3'd5: begin idx_a = 4'd2; idx_b = 4'd5; idx_c = 4'd8; end
         3'd6: begin idx_a = 4'd0; idx_b = 4'd4; idx_c = 4'd8; end
         3'd7: begin idx_a = 4'd2; idx_b = 4'd4; idx_c = 4'd6; end
         default: ;
      endcase
   end

   detect_3inarow u_det (
      .cell_a (cells[idx_a]),
      .cell_b (cells[idx_b]),
      .cell_c (cells[idx_c]),
      .winner (det_winner),
      .who    (det_who)
   );

   // Out-of-range positions read as an occupied cell so they fall out as illegal.
   assign pos_cell   = (mv.move_pos <= 4'd8) ? cells[mv.move_pos] : 2'b11;
   assign move_legal = (pos_cell == 2'b00);

   always_comb begin
      state_d     = state_q;
      board_d     = board_q;
      turn_d      = turn_q;
      move_cnt_d  = move_cnt_q;
      line_cnt_d  = line_cnt_q;
      hit_d       = hit_q;
      hit_line_d  = hit_line_q;
      hit_who_d   = hit_who_q;
      illegal_d   = 1'b0;
      game_over_d = game_over_q;
      who_win_d   = who_win_q;
      win_line_d  = win_line_q;
      draw_d      = draw_q;

      if (new_game) begin
         state_d     = WAIT;
         board_d     = '0;
         turn_d      = FIRST_PLAYER;
         move_cnt_d  = '0;
         line_cnt_d  = '0;
         hit_d       = 1'b0;
         hit_line_d  = '0;
         hit_who_d   = '0;
         game_over_d = 1'b0;
         who_win_d   = '0;
         win_line_d  = '0;
         draw_d      = 1'b0;
      end else begin
         case (state_q)
            WAIT: begin
               if (mv.move_valid) begin
                  if (move_legal) begin
                     board_d[{mv.move_pos, 1'b0} +: 2] = turn_q;
                     move_cnt_d = move_cnt_q + 4'd1;
                     line_cnt_d = '0;
                     hit_d      = 1'b0;
                     hit_line_d = '0;
                     hit_who_d  = '0;
                     state_d    = SCAN;
                  end else begin
                     illegal_d = 1'b1;
                  end
               end
            end
            SCAN: begin
               if (det_winner && !hit_q) begin
                  hit_d      = 1'b1;
                  hit_line_d = line_cnt_q;
                  hit_who_d  = det_who;
               end
               if (line_cnt_q == 3'd7) begin
                  // Line 7 is folded in combinationally so the verdict lands on this edge.
                  if (hit_q || det_winner) begin
                     who_win_d   = hit_q ? hit_who_q  : det_who;
                     win_line_d  = hit_q ? hit_line_q : 3'd7;
                     game_over_d = 1'b1;
                     state_d     = DONE;
                  end else if (move_cnt_q == 4'd9) begin
                     draw_d      = 1'b1;
                     game_over_d = 1'b1;
                     state_d     = DONE;
                  end else begin
                     turn_d  = turn_q ^ 2'b11;
                     state_d = WAIT;
                  end
               end else begin
                  line_cnt_d = line_cnt_q + 3'd1;
               end
            end
            DONE: ;
            default: state_d = WAIT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= WAIT;
         board_q     <= '0;
         turn_q      <= FIRST_PLAYER;
         move_cnt_q  <= '0;
         line_cnt_q  <= '0;
         hit_q       <= 1'b0;
         hit_line_q  <= '0;
         hit_who_q   <= '0;
         illegal_q   <= 1'b0;
         game_over_q <= 1'b0;
         who_win_q   <= '0;
         win_line_q  <= '0;
         draw_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         board_q     <= board_d;
         turn_q      <= turn_d;
         move_cnt_q  <= move_cnt_d;
         line_cnt_q  <= line_cnt_d;
         hit_q       <= hit_d;
         hit_line_q  <= hit_line_d;
         hit_who_q   <= hit_who_d;
         illegal_q   <= illegal_d;
         game_over_q <= game_over_d;
         who_win_q   <= who_win_d;
         win_line_q  <= win_line_d;
         draw_q      <= draw_d;
      end
   end

   assign mv.move_ready = (state_q == WAIT);
   assign board         = board_q;
   assign turn          = turn_q;
   assign illegal_move  = illegal_q;
   assign game_over     = game_over_q;
   assign who_win       = who_win_q;
   assign win_line      = win_line_q;
   assign draw          = draw_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Bench for ttt_game_ctrl: directed games plus random play against a
// game-rules reference model.
module tb_ttt_game_ctrl;
   logic        clk;
   logic        rst_n;
   logic        new_game;
   logic [17:0] board;
   logic [1:0]  turn;
   logic        illegal_move;
   logic        game_over;
   logic [1:0]  who_win;
   logic [2:0]  win_line;
   logic        draw;

   ttt_game_ctrl_if mif ();

   ttt_game_ctrl #(.FIRST_PLAYER(2'b01)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .new_game     (new_game),
      .mv           (mif.slave),
      .board        (board),
      .turn         (turn),
      .illegal_move (illegal_move),
      .game_over    (game_over),
      .who_win      (who_win),
      .win_line     (win_line),
      .draw         (draw)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // reference model: the game in plain terms
   int         lines_tbl [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                                    '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
   logic [1:0] m_cells [9];
   logic [1:0] m_turn;
   int         m_moves;
   bit         m_over;
   logic [1:0] m_who;
   logic [2:0] m_line;
   bit         m_draw;

   function automatic logic [17:0] m_board();
      logic [17:0] b;
      b = '0;
      for (int i = 0; i < 9; i++) b[2*i +: 2] = m_cells[i];
      return b;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 9; i++) m_cells[i] = 2'b00;
      m_turn = 2'b01; m_moves = 0; m_over = 0;
      m_who = 2'b00; m_line = 3'd0; m_draw = 0;
   endtask

   task automatic model_judge();
      bit found;
      found = 0;
      for (int l = 0; l < 8; l++) begin
         if (!found && m_cells[lines_tbl[l][0]] != 2'b00 &&
             m_cells[lines_tbl[l][0]] == m_cells[lines_tbl[l][1]] &&
             m_cells[lines_tbl[l][1]] == m_cells[lines_tbl[l][2]]) begin
            found  = 1;
            m_who  = m_cells[lines_tbl[l][0]];
            m_line = 3'(l);
         end
      end
      if (found) m_over = 1;
      else if (m_moves == 9) begin m_over = 1; m_draw = 1; end
      else m_turn = (m_turn == 2'b01) ? 2'b10 : 2'b01;
   endtask

   task automatic check_results(input string tag);
      chk({tag, "_over"}, game_over, m_over);
      chk({tag, "_who"},  who_win,   m_who);
      chk({tag, "_line"}, win_line,  m_line);
      chk({tag, "_draw"}, draw,      m_draw);
      chk({tag, "_turn"}, turn,      m_turn);
      chk({tag, "_ready"}, mif.move_ready, !m_over);
   endtask

   // Called and returns at a negedge with move_valid low.
   task automatic do_move(input logic [3:0] pos);
      bit legal;
      int busy;
      legal = !m_over && pos <= 4'd8 && m_cells[pos] == 2'b00;
      mif.move_valid = 1'b1;
      mif.move_pos   = pos;
      @(posedge clk);
      @(negedge clk);
      mif.move_valid = 1'b0;
      if (m_over) begin
         chk("over_ready", mif.move_ready, 1'b0);
         chk("over_board", board, m_board());
         chk("over_illegal", illegal_move, 1'b0);
         chk("over_hold", game_over, 1'b1);
      end else if (legal) begin
         m_cells[pos] = m_turn;
         m_moves++;
         chk("mv_board", board, m_board());
         chk("mv_illegal", illegal_move, 1'b0);
         busy = (mif.move_ready == 1'b0) ? 1 : 0;
         repeat (7) begin
            @(negedge clk);
            if (mif.move_ready == 1'b0 && game_over == 1'b0) busy++;
         end
         chk("scan_busy", busy, 8);
         @(negedge clk);
         model_judge();
         check_results("res");
      end else begin
         chk("ill_pulse", illegal_move, 1'b1);
         chk("ill_board", board, m_board());
         chk("ill_turn", turn, m_turn);
         chk("ill_ready", mif.move_ready, 1'b1);
         @(negedge clk);
         chk("ill_once", illegal_move, 1'b0);
      end
   endtask

   task automatic start_new(input bit with_move);
      new_game       = 1'b1;
      mif.move_valid = with_move;
      mif.move_pos   = 4'd0;
      @(posedge clk);
      @(negedge clk);
      new_game       = 1'b0;
      mif.move_valid = 1'b0;
      model_clear();
      chk("ng_board", board, 18'd0);
      chk("ng_illegal", illegal_move, 1'b0);
      check_results("ng");
   endtask

   task automatic play(input int moves[$]);
      foreach (moves[i]) do_move(4'(moves[i]));
   endtask

   int guard;
   logic [3:0] rpos;
   int empties[$];

   initial begin
      rst_n = 1'b0;
      new_game = 1'b0;
      mif.move_valid = 1'b0;
      mif.move_pos = 4'd0;
      model_clear();
      repeat (2) @(negedge clk);
      chk("rst_board", board, 18'd0);
      check_results("rst");
      chk("rst_illegal", illegal_move, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      // first move, then illegal repeats
      do_move(4'd4);
      chk("first_cell", board[9:8], 2'b01);
      do_move(4'd4);
      do_move(4'd12);
      chk("ill_turn_keep", turn, 2'b10);
      start_new(1'b0);

      play('{0, 3, 1, 4, 2});
      chk("row_win_line", win_line, 3'd0);
      do_move(4'd8);
      start_new(1'b1);

      play('{0, 1, 2, 4, 3, 5, 7, 6, 8});
      chk("draw_flag", draw, 1'b1);
      start_new(1'b0);

      play('{1, 3, 2, 5, 4, 6, 8, 7, 0});
      chk("win9_who", who_win, 2'b01);
      chk("win9_nodraw", draw, 1'b0);
      start_new(1'b0);

      // new_game three cycles after an accept, with a concurrent move offer
      mif.move_valid = 1'b1; mif.move_pos = 4'd4;
      @(posedge clk); @(negedge clk);
      mif.move_valid = 1'b0;
      repeat (2) @(negedge clk);
      start_new(1'b1);
      repeat (10) @(negedge clk);
      chk("ng_stale_board", board, 18'd0);
      check_results("ng_stale");

      // reset mid-scan
      mif.move_valid = 1'b1; mif.move_pos = 4'd2;
      @(posedge clk); @(negedge clk);
      mif.move_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_clear();
      chk("rstmid_board", board, 18'd0);
      chk("rstmid_ready", mif.move_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("rstmid_stale_board", board, 18'd0);
      check_results("rstmid_stale");

      // random games
      for (int g = 0; g < 20; g++) begin
         guard = 0;
         while (!m_over && guard < 60) begin
            guard++;
            if ($urandom_range(0, 3) == 0) rpos = 4'($urandom_range(0, 15));
            else begin
               empties.delete();
               for (int i = 0; i < 9; i++) if (m_cells[i] == 2'b00) empties.push_back(i);
               rpos = 4'(empties[$urandom_range(0, empties.size() - 1)]);
            end
            do_move(rpos);
         end
         chk("rand_ended", m_over, 1'b1);
         do_move(4'($urandom_range(0, 15)));
         start_new(1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
